register_file: RTL and testbench

//   32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.

---
 rtl/register_file.sv | 111 +++++++++++
 tb/tb_register_file.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32 x 32-bit MIPS general-purpose register file for the single-cycle
//   datapath. It has one synchronous write port for the writeback result and
//   two combinational read ports that drive the ALU operands. It also has a
//   debug read port that returns the stored value and is never forwarded.
//   Register $0 always reads zero. Writes to $0 are dropped.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width; depth = 2**ADDR_W
//   BYPASS  1 = a same-cycle write is forwarded to regA/regB
//           0 = reads see the stored value only
//
// Ports
//   clock       in   rising-edge clock for all state
//   reset       in   synchronous active-high clear of every register; also
//                    forces regA/regB/dbg_data to 0 while asserted
//   read_reg1   in   rs address      -> regA
//   read_reg2   in   rt address      -> regB
//   write_reg   in   destination address
//   write_data  in   writeback value
//   reg_write   in   write enable
//   regA        out  operand A
//   regB        out  operand B (before the ALUSrc mux)
//   dbg_addr    in   debug read address
//   dbg_data    out  debug read data (stored value, no bypass)
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 2;

  // Register storage. The reads are asynchronous and reset clears every
  // entry, so this array is built from flip-flops, not block RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // A write to $0 is never a hit. Entry 0 therefore keeps its reset value.
  // The read paths also force address 0 to zero.
  logic wr_hit;
  assign wr_hit = reg_write && (write_reg != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[write_reg] = write_data;
    end
  end

  // Reset takes priority. A write on a reset edge is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand read ports. Each port is combinational.
  // Forwarding uses the raw write enable. A forwarded write to $0 has no
  // effect because the zero-address check comes first.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [NPORT];
  logic [DATA_W-1:0] rd_data [NPORT];

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd_port
      logic fwd;
      assign fwd = (BYPASS != 0) && reg_write && (write_reg == rd_addr[gi]);

      always_comb begin
        rd_data[gi] = mem_q[rd_addr[gi]];
        if (reset || (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end else if (fwd) begin
          rd_data[gi] = write_data;
        end
      end
    end
  endgenerate

  assign regA = rd_data[0];
  assign regB = rd_data[1];

  // The debug port returns the stored value only. It never forwards.
  assign dbg_data = (reset || (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] regA, regB, dbg_data;
  logic [31:0] regA_nb, regB_nb, dbg_data_nb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the architectural contents of the 32 registers.
  logic [31:0] model [32];

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .regA(regA), .regB(regB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .regA(regA_nb), .regB(regB_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  // Expected read value, worked out from the architectural rules.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
    if (reset) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && reg_write && (write_reg == a)) return write_data;
    return model[a];
  endfunction

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic clk_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (reg_write && (write_reg != 5'd0)) begin
      model[write_reg] = write_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    read_reg1 = 5'd3; read_reg2 = 5'd9; dbg_addr = 5'd7;
    #1;
    n_checks++;
    if (regA !== 32'h0 || regB !== 32'h0 || dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_forced: regA=%h regB=%h dbg=%h required 0", regA, regB, dbg_data);
    end
    clk_edge();
    clk_edge();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      n_checks++;
      if (dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_dbg r%0d: got %h required 0", i, dbg_data);
      end
    end
    n_checks++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ports: regA=%h regB=%h required 0", regA, regB);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    logic [31:0] alu_result;
    idle_inputs();
    reg_write = 1'b1; write_reg = 5'd1; write_data = 32'd7;
    clk_edge();
    write_reg = 5'd2; write_data = 32'd8;
    clk_edge();
    idle_inputs();
    read_reg1 = 5'd1; read_reg2 = 5'd2;
    #1;
    alu_result = regA + regB;
    n_checks++;
    if (regA !== 32'd7 || regB !== 32'd8) begin
      n_fail++;
      $display("FAIL write_read: regA=%0d regB=%0d required 7 8", regA, regB);
    end
    n_checks++;
    if (alu_result !== 32'd15) begin
      n_fail++;
      $display("FAIL alu_add: result=%0d required 15", alu_result);
    end
    $display("test_write_read regA=%0d regB=%0d sum=%0d", regA, regB, alu_result);
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hDEADBEEF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    n_checks++;
    if (regA !== 32'h0 || regB !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_before: regA=%h regB=%h required 0", regA, regB);
    end
    clk_edge();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (regA !== 32'h0 || dbg_data !== 32'h0 || dbg_data_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_after: regA=%h dbg=%h required 0", regA, dbg_data);
    end
    $display("test_zero_reg regA=%h", regA);
  endtask

  task automatic test_bypass();
    idle_inputs();
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'd3;
    clk_edge();
    write_data = 32'd4; read_reg1 = 5'd4; read_reg2 = 5'd4; dbg_addr = 5'd4;
    #1;
    n_checks++;
    if (regA !== 32'd4 || regB !== 32'd4) begin
      n_fail++;
      $display("FAIL bypass_fwd: regA=%0d regB=%0d required 4 4", regA, regB);
    end
    n_checks++;
    if (regA_nb !== 32'd3 || regB_nb !== 32'd3) begin
      n_fail++;
      $display("FAIL nobypass_old: regA=%0d regB=%0d required 3 3", regA_nb, regB_nb);
    end
    n_checks++;
    if (dbg_data !== 32'd3) begin
      n_fail++;
      $display("FAIL dbg_no_fwd: got %0d required 3", dbg_data);
    end
    clk_edge();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (regA !== 32'd4 || regB_nb !== 32'd4 || regA_nb !== 32'd4) begin
      n_fail++;
      $display("FAIL bypass_after: regA=%0d regA_nb=%0d regB_nb=%0d required 4", regA, regA_nb, regB_nb);
    end
    $display("test_bypass regA=%0d regA_nb=%0d", regA, regA_nb);
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    reset = 1'b1;
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h12345678;
    read_reg1 = 5'd5; read_reg2 = 5'd4;
    #1;
    n_checks++;
    if (regA !== 32'h0 || regB !== 32'h0 || regA_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_forced: regA=%h regB=%h required 0", regA, regB);
    end
    clk_edge();
    reset = 1'b0; reg_write = 1'b0; dbg_addr = 5'd5;
    #1;
    n_checks++;
    if (dbg_data !== 32'h0 || regA !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_priority: r5=%h regA=%h required 0", dbg_data, regA);
    end
    dbg_addr = 5'd4;
    #1;
    n_checks++;
    if (dbg_data !== 32'h0 || regB !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_clears_old: r4=%h regB=%h required 0", dbg_data, regB);
    end
    reg_write = 1'b1; write_reg = 5'd6; write_data = 32'hA5A5_0001;
    clk_edge();
    reg_write = 1'b0; dbg_addr = 5'd6;
    #1;
    n_checks++;
    if (dbg_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL first_write: r6=%h required a5a50001", dbg_data);
    end
    $display("test_reset_priority r6=%h", dbg_data);
  endtask

  task automatic test_full_sweep();
    logic [31:0] ea, eb;
    idle_inputs();
    reg_write = 1'b1;
    for (int i = 1; i < 32; i++) begin
      write_reg = 5'(i);
      write_data = i * 32'h01010101;
      clk_edge();
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      ea = i * 32'h01010101;
      eb = (31 - i) * 32'h01010101;
      n_checks++;
      if (regA !== ea || regB !== eb || regA_nb !== ea || regB_nb !== eb) begin
        n_fail++;
        $display("FAIL sweep (%0d,%0d): regA=%h regB=%h required %h %h", i, 31 - i, regA, regB, ea, eb);
      end
    end
    $display("test_full_sweep done");
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, ea_nb, eb_nb, ed;
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 29) == 0);
      reg_write  = $urandom_range(0, 1);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      #1;
      ea = ref_read(read_reg1, 1'b1);
      eb = ref_read(read_reg2, 1'b1);
      ea_nb = ref_read(read_reg1, 1'b0);
      eb_nb = ref_read(read_reg2, 1'b0);
      ed = ref_read(dbg_addr, 1'b0);
      n_checks++;
      if (regA !== ea || regB !== eb || regA_nb !== ea_nb || regB_nb !== eb_nb
          || dbg_data !== ed || dbg_data_nb !== ed) begin
        n_fail++;
        $display("FAIL random #%0d: A=%h B=%h Anb=%h Bnb=%h D=%h required %h %h %h %h %h",
                 n, regA, regB, regA_nb, regB_nb, dbg_data, ea, eb, ea_nb, eb_nb, ed);
      end
      clk_edge();
    end
    reset = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b0;
    idle_inputs();
    @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_reset_priority();
    test_full_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
